// File: rtl/range_frame_sender_if.sv
// ============================================================================
// Module   : range_frame_sender_if
// Function : Host-side load/start bus and range-finder frame outputs.
//            RANGE_SENDER_REF_EN adds the exp_range/exp_valid reference outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface range_frame_sender_if #(
  parameter int WIDTH = 10
);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             wr_drop;
  logic             start;
  logic             start_err;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             busy;
  logic             done;
`ifdef RANGE_SENDER_REF_EN
  logic [WIDTH-1:0] exp_range;
  logic             exp_valid;

  modport master (
    output wr_en, wr_data, start,
    input  wr_ready, wr_drop, start_err, data_out, go, finish, busy, done,
    input  exp_range, exp_valid
  );

  modport slave (
    input  wr_en, wr_data, start,
    output wr_ready, wr_drop, start_err, data_out, go, finish, busy, done,
    output exp_range, exp_valid
  );
`else
  modport master (
    output wr_en, wr_data, start,
    input  wr_ready, wr_drop, start_err, data_out, go, finish, busy, done
  );

  modport slave (
    input  wr_en, wr_data, start,
    output wr_ready, wr_drop, start_err, data_out, go, finish, busy, done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/range_frame_sender.sv
// ============================================================================
// Module   : range_frame_sender
// Function : Buffers up to DEPTH samples and replays them as one go/finish
//            framed burst. RANGE_SENDER_REF_EN adds min/max range reference.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module range_frame_sender #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  wire logic           clock,
  input  wire logic           reset_n,
  range_frame_sender_if.slave bus
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam int              AW      = CW - 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   ONE_C   = CW'(1);
  localparam logic [CW-1:0]   TWO_C   = CW'(2);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    n_q, n_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             go_q, go_d;
  logic             finish_q, finish_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_drop_q, wr_drop_d;
  logic             start_err_q, start_err_d;

  logic             wr_ready;
  logic             start_acc;
  logic             wr_acc;
  logic             beat_en;
  logic [WIDTH-1:0] beat_data;

  assign wr_ready  = (state_q == IDLE) && (count_q < DEPTH_C);
  assign start_acc = (state_q == IDLE) && bus.start && (count_q >= TWO_C);
  assign wr_acc    = bus.wr_en && wr_ready && !start_acc;
  // SEND spends n beat cycles (idx < n) followed by one done cycle (idx == n).
  assign beat_en   = (state_q == SEND) && (idx_q < n_q);
  assign beat_data = mem_q[idx_q[AW-1:0]];

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    count_d     = count_q;
    idx_d       = idx_q;
    n_d         = n_q;
    data_out_d  = data_out_q;
    go_d        = 1'b0;
    finish_d    = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    wr_drop_d   = bus.wr_en && !wr_acc;
    start_err_d = bus.start && !start_acc;

    if (wr_acc) begin
      mem_d[count_q[AW-1:0]] = bus.wr_data;
      count_d                = count_q + ONE_C;
    end

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = SEND;
          idx_d   = '0;
          n_d     = count_q;
        end
      end
      SEND: begin
        if (beat_en) begin
          data_out_d = beat_data;
          go_d       = (idx_q == '0);
          finish_d   = (idx_q == (n_q - ONE_C));
          busy_d     = 1'b1;
          idx_d      = idx_q + ONE_C;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_q       <= '{default: '0};
      count_q     <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      data_out_q  <= '0;
      go_q        <= 1'b0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_drop_q   <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      data_out_q  <= data_out_d;
      go_q        <= go_d;
      finish_q    <= finish_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_drop_q   <= wr_drop_d;
      start_err_q <= start_err_d;
    end
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.wr_drop   = wr_drop_q;
  assign bus.start_err = start_err_q;
  assign bus.data_out  = data_out_q;
  assign bus.go        = go_q;
  assign bus.finish    = finish_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef RANGE_SENDER_REF_EN
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] exp_range_q, exp_range_d;
  logic             exp_valid_q, exp_valid_d;

  // Beat 0 seeds the extremes so no stale frame leaks into the next range.
  always_comb begin
    min_d       = min_q;
    max_d       = max_q;
    exp_range_d = exp_range_q;
    exp_valid_d = 1'b0;
    if (beat_en) begin
      if (idx_q == '0) begin
        min_d = beat_data;
        max_d = beat_data;
      end else begin
        if (beat_data < min_q) min_d = beat_data;
        if (beat_data > max_q) max_d = beat_data;
      end
    end
    if ((state_q == SEND) && !beat_en) begin
      exp_range_d = max_q - min_q;
      exp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      min_q       <= '0;
      max_q       <= '0;
      exp_range_q <= '0;
      exp_valid_q <= 1'b0;
    end else begin
      min_q       <= min_d;
      max_q       <= max_d;
      exp_range_q <= exp_range_d;
      exp_valid_q <= exp_valid_d;
    end
  end

  assign bus.exp_range = exp_range_q;
  assign bus.exp_valid = exp_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_range_frame_sender.sv
// ============================================================================
// Module   : tb_range_frame_sender
// Function : Directed and randomized frames checked against a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_range_frame_sender;

  localparam int W = 10;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  int             checks = 0;
  int             errors = 0;
  logic [W-1:0]   model[$];

  range_frame_sender_if #(.WIDTH(W)) bus ();

  range_frame_sender #(.WIDTH(W), .DEPTH(D)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_one(input logic [W-1:0] d);
    bit acc;
    acc = (model.size() < D);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    chk("wr_ready", bus.wr_ready, acc);
    tick();
    bus.wr_en = 1'b0;
    chk("wr_drop", bus.wr_drop, !acc);
    if (acc) model.push_back(d);
  endtask

  task automatic reject_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_err", bus.start_err, 1);
    chk("no_go_after_reject", bus.go, 0);
    tick();
    chk("start_err_pulse", bus.start_err, 0);
    chk("no_busy_after_reject", bus.busy, 0);
  endtask

  // Replays the model queue as the expected frame; optionally disturbs it.
  task automatic run_frame(input bit wr_with_start, input bit poke_req);
    int           n;
    bit           poke;
    logic [W-1:0] mn;
    logic [W-1:0] mx;
    n    = model.size();
    poke = poke_req && (n >= 3);
    mn   = model[0];
    mx   = model[0];
    foreach (model[i]) begin
      if (model[i] < mn) mn = model[i];
      if (model[i] > mx) mx = model[i];
    end
    bus.start   = 1'b1;
    bus.wr_en   = wr_with_start;
    bus.wr_data = W'($urandom);
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    chk("start_err_on_accept", bus.start_err, 0);
    chk("wr_drop_with_start", bus.wr_drop, wr_with_start);
    chk("go_latency", bus.go, 0);
    chk("busy_latency", bus.busy, 0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("data_out", bus.data_out, model[i]);
      chk("go", bus.go, (i == 0));
      chk("finish", bus.finish, (i == n - 1));
      chk("busy", bus.busy, 1);
      chk("done_early", bus.done, 0);
      chk("wr_ready_send", bus.wr_ready, 0);
      if (poke && i == 2) begin
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        chk("wr_drop_send", bus.wr_drop, 1);
        chk("start_err_send", bus.start_err, 1);
      end
      if (poke && i == 1) begin
        bus.wr_en = 1'b1;
        bus.start = 1'b1;
      end
    end
    tick();
    chk("done", bus.done, 1);
    chk("go_after", bus.go, 0);
    chk("finish_after", bus.finish, 0);
    chk("busy_after", bus.busy, 0);
    chk("data_hold", bus.data_out, model[n-1]);
    chk("wr_ready_done", bus.wr_ready, 1);
`ifdef RANGE_SENDER_REF_EN
    chk("exp_valid", bus.exp_valid, 1);
    chk("exp_range", bus.exp_range, mx - mn);
`endif
    model.delete();
    tick();
    chk("done_pulse", bus.done, 0);
    chk("data_hold_idle", bus.data_out, n == 0 ? 0 : bus.data_out);
`ifdef RANGE_SENDER_REF_EN
    chk("exp_valid_pulse", bus.exp_valid, 0);
    chk("exp_range_hold", bus.exp_range, mx - mn);
`endif
  endtask

  initial begin
    int n;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    reset_n     = 1'b0;
    tick();
    tick();
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_go", bus.go, 0);
    chk("rst_finish", bus.finish, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wr_drop", bus.wr_drop, 0);
    chk("rst_start_err", bus.start_err, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    reset_n = 1'b1;
    tick();

    // Four-sample frame with known data.
    write_one(10'd5);
    write_one(10'd9);
    write_one(10'd2);
    write_one(10'd7);
    run_frame(1'b0, 1'b0);

    // Too-short frame is rejected, then completed to two samples.
    write_one(W'($urandom));
    reject_start();
    write_one(W'($urandom));
    run_frame(1'b0, 1'b0);

    // Overfill: the DEPTH+1-th write drops; disturb the frame while sending.
    for (int i = 0; i < D + 1; i++) write_one(W'($urandom));
    run_frame(1'b0, 1'b1);

    // Write concurrent with an accepted start is dropped.
    for (int i = 0; i < 3; i++) write_one(W'($urandom));
    run_frame(1'b1, 1'b1);

    // Reset in the middle of a six-beat frame.
    for (int i = 0; i < 6; i++) write_one(W'($urandom));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_data", bus.data_out, model[i]);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t5_go", bus.go, 0);
    chk("t5_finish", bus.finish, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_data_clr", bus.data_out, 0);
    model.delete();
    repeat (4) begin
      tick();
      chk("t5_no_done", bus.done, 0);
      chk("t5_no_busy", bus.busy, 0);
    end
    reject_start();

    // Randomized frames.
    repeat (8) begin
      n = $urandom_range(2, D);
      for (int i = 0; i < n; i++) write_one(W'($urandom));
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef RANGE_SENDER_REF_EN
    write_one(10'd300);
    write_one(10'd12);
    write_one(10'd1023);
    write_one(10'd40);
    run_frame(1'b0, 1'b0);
    chk("t6_range", bus.exp_range, 1011);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
